// File: rtl/sensor_conditioner.sv
// sensor_conditioner: synchronizes and debounces the door/alarm/window/temperature
// sensor lines, and emits a one-cycle event pulse when any conditioned output changes.
// Optional feature macro: SENSOR_COND_TEMP_DEBOUNCE_EN. When defined, the temperature
// word is debounced as a whole. When undefined, it is the synchronized bus.
module sensor_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TEMP_W          = 6,
    parameter int unsigned TEMP_RESET      = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              raw_SFD,
    input  logic              raw_SRD,
    input  logic              raw_SFA,
    input  logic              raw_SW,
    input  logic              raw_ST,
    input  logic [TEMP_W-1:0] raw_temperature,
    output logic              SFD,
    output logic              SRD,
    output logic              SFA,
    output logic              SW,
    output logic              ST,
    output logic [TEMP_W-1:0] temperature,
    output logic              sensor_event
);

    localparam int unsigned       CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [TEMP_W-1:0] TEMP_INIT = TEMP_W'(TEMP_RESET);

    // Bit order for the five sensors: 0 SFD, 1 SRD, 2 SFA, 3 SW, 4 ST
    logic [4:0]              w_raw;
    logic [4:0]              r_s1;
    logic [4:0]              r_s2;
    logic [TEMP_W-1:0]       r_ts1;
    logic [TEMP_W-1:0]       r_ts2;
    logic [4:0]              r_sens;
    logic [4:0]              w_sens_nxt;
    logic [4:0][CNT_W-1:0]   r_cnt;
    logic [4:0][CNT_W-1:0]   w_cnt_nxt;
    logic [TEMP_W-1:0]       w_temp_cur;
    logic [TEMP_W-1:0]       w_temp_nxt;
    logic                    r_event;

    assign w_raw = {raw_ST, raw_SW, raw_SFA, raw_SRD, raw_SFD};

    // Two-flop synchronizers for every raw sensor bit and the temperature bus
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_ts1 <= TEMP_INIT;
            r_ts2 <= TEMP_INIT;
        end else begin
            r_s1  <= w_raw;
            r_s2  <= r_s1;
            r_ts1 <= raw_temperature;
            r_ts2 <= r_ts1;
        end
    end

    // Per-bit debounce: output follows s2 only after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        w_sens_nxt = r_sens;
        w_cnt_nxt  = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            if (r_s2[i] != r_sens[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_sens_nxt[i] = r_s2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Sensor output and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sens <= '0;
            r_cnt  <= '0;
        end else begin
            r_sens <= w_sens_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

`ifdef SENSOR_COND_TEMP_DEBOUNCE_EN
    logic [TEMP_W-1:0] r_temp;
    logic [TEMP_W-1:0] r_tprev;
    logic [CNT_W-1:0]  r_tcnt;
    logic [CNT_W-1:0]  w_tcnt_nxt;

    // Word debounce: s2 must match its previous sample long enough, so skewed codes never pass
    always_comb begin
        w_temp_nxt = r_temp;
        w_tcnt_nxt = '0;
        if ((r_ts2 == r_tprev) && (r_ts2 != r_temp)) begin
            if (r_tcnt == CNT_LAST) begin
                w_temp_nxt = r_ts2;
            end else begin
                w_tcnt_nxt = r_tcnt + CNT_ONE;
            end
        end
    end

    // Temperature output, previous-sample and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_temp  <= TEMP_INIT;
            r_tprev <= TEMP_INIT;
            r_tcnt  <= '0;
        end else begin
            r_temp  <= w_temp_nxt;
            r_tprev <= r_ts2;
            r_tcnt  <= w_tcnt_nxt;
        end
    end

    assign w_temp_cur = r_temp;
`else
    // Without word debounce the output is s2 itself, so its next value is s1
    assign w_temp_cur = r_ts2;
    assign w_temp_nxt = r_ts1;
`endif

    // Event pulse: registered flag set on the same edge any output takes a new value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_event <= 1'b0;
        end else begin
            r_event <= (w_sens_nxt != r_sens) || (w_temp_nxt != w_temp_cur);
        end
    end

    assign SFD          = r_sens[0];
    assign SRD          = r_sens[1];
    assign SFA          = r_sens[2];
    assign SW           = r_sens[3];
    assign ST           = r_sens[4];
    assign temperature  = w_temp_cur;
    assign sensor_event = r_event;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Self-checking bench for sensor_conditioner: table-driven vectors plus hand-written
// multi-cycle sequences, with expected results queued at stimulus time.
module tb_sensor_conditioner;

    localparam int unsigned N     = 4;
    localparam int          S_LAT = 2 + N;
`ifdef SENSOR_COND_TEMP_DEBOUNCE_EN
    localparam int          T_LAT = 3 + N;
    localparam int          TOGGLE_EV = 0;
    localparam int          TOGGLE_TEDGE = 0;
`else
    localparam int          T_LAT = 2;
    localparam int          TOGGLE_EV = 8;
    localparam int          TOGGLE_TEDGE = 2;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] raw;
    logic [5:0] rtemp;
    logic       SFD, SRD, SFA, SW, ST;
    logic [5:0] temperature;
    logic       sensor_event;
    logic [4:0] sens;

    assign sens = {ST, SW, SFA, SRD, SFD};

    always #5 clk = ~clk;

    sensor_conditioner #(
        .DEBOUNCE_CYCLES(N),
        .TEMP_W(6),
        .TEMP_RESET(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .raw_SFD(raw[0]),
        .raw_SRD(raw[1]),
        .raw_SFA(raw[2]),
        .raw_SW(raw[3]),
        .raw_ST(raw[4]),
        .raw_temperature(rtemp),
        .SFD(SFD),
        .SRD(SRD),
        .SFA(SFA),
        .SW(SW),
        .ST(ST),
        .temperature(temperature),
        .sensor_event(sensor_event)
    );

    typedef struct {
        int         id;
        logic [4:0] sens;
        logic [5:0] temp;
        int         sedge;
        int         tedge;
        int         ev;
    } exp_t;

    typedef struct {
        int         id;
        logic [4:0] raw;
        logic [5:0] rtemp;
        int         hold;
        logic [4:0] sens;
        logic [5:0] temp;
        int         sedge;
        int         tedge;
        int         ev;
    } vec_t;

    exp_t       q[$];
    int         checks   = 0;
    int         failures = 0;

    bit         mon_on = 1'b0;
    int         mon_edge, mon_sedge, mon_tedge, mon_ev;
    logic [4:0] mon_s0;
    logic [5:0] mon_t0;

    // Observe outputs 1 time unit after each rising edge while a window is open
    always @(posedge clk) begin
        #1;
        if (mon_on) begin
            mon_edge++;
            if (mon_sedge == 0 && sens != mon_s0) mon_sedge = mon_edge;
            if (mon_tedge == 0 && temperature != mon_t0) mon_tedge = mon_edge;
            if (sensor_event) mon_ev++;
        end
    end

    function automatic exp_t mk(input int id, input logic [4:0] s, input logic [5:0] t,
                                input int se, input int te, input int ev);
        exp_t e;
        e.id = id; e.sens = s; e.temp = t; e.sedge = se; e.tedge = te; e.ev = ev;
        return e;
    endfunction

    function automatic vec_t mkv(input int id, input logic [4:0] r, input logic [5:0] rt,
                                 input int hold, input logic [4:0] s, input logic [5:0] t,
                                 input int se, input int te, input int ev);
        vec_t v;
        v.id = id; v.raw = r; v.rtemp = rt; v.hold = hold;
        v.sens = s; v.temp = t; v.sedge = se; v.tedge = te; v.ev = ev;
        return v;
    endfunction

    task automatic check(input string what, input int id, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s id=%0d: got %0d expected %0d", what, id, act, exp);
        end
    endtask

    task automatic start_mon();
        mon_s0    = sens;
        mon_t0    = temperature;
        mon_edge  = 0;
        mon_sedge = 0;
        mon_tedge = 0;
        mon_ev    = 0;
        mon_on    = 1'b1;
    endtask

    task automatic end_mon();
        exp_t e;
        mon_on = 1'b0;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: queue empty at window end");
        end else begin
            e = q.pop_front();
            check("sens_final",  e.id, int'(sens),        int'(e.sens));
            check("temp_final",  e.id, int'(temperature), int'(e.temp));
            check("sens_edge",   e.id, mon_sedge,         e.sedge);
            check("temp_edge",   e.id, mon_tedge,         e.tedge);
            check("event_count", e.id, mon_ev,            e.ev);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        raw   = v.raw;
        rtemp = v.rtemp;
        q.push_back(mk(v.id, v.sens, v.temp, v.sedge, v.tedge, v.ev));
        start_mon();
        repeat (v.hold) @(negedge clk);
        end_mon();
    endtask

    vec_t tab[7];

    initial begin
        tab[0] = mkv(1, 5'b00000, 6'd20, 10, 5'b00000, 6'd20, S_LAT, T_LAT, 2);
        tab[1] = mkv(2, 5'b00001, 6'd20, 10, 5'b00001, 6'd20, S_LAT, 0,     1);
        tab[2] = mkv(3, 5'b10011, 6'd20, 10, 5'b10011, 6'd20, S_LAT, 0,     1);
        tab[3] = mkv(4, 5'b10011, 6'd31, 10, 5'b10011, 6'd31, 0,     T_LAT, 1);
        tab[4] = mkv(5, 5'b00000, 6'd10, 10, 5'b00000, 6'd10, S_LAT, T_LAT, 2);
        tab[5] = mkv(6, 5'b00000, 6'd10, 6,  5'b00000, 6'd10, 0,     0,     0);
        tab[6] = mkv(7, 5'b00000, 6'd22, 10, 5'b00000, 6'd22, 0,     T_LAT, 1);

        // Reset held with all raws high and a hot temperature
        raw   = 5'b11111;
        rtemp = 6'd45;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_sens",  0, int'(sens),         0);
        check("reset_temp",  0, int'(temperature),  20);
        check("reset_event", 0, int'(sensor_event), 0);
        reset = 1'b1;
        q.push_back(mk(100, 5'b11111, 6'd45, S_LAT, T_LAT, 2));
        start_mon();
        repeat (10) @(negedge clk);
        end_mon();

        for (int i = 0; i < 7; i++) run_vec(tab[i]);

        // SW glitches of 3 cycles separated by 2 low cycles never pass
        @(negedge clk);
        q.push_back(mk(200, 5'b00000, 6'd22, 0, 0, 0));
        start_mon();
        for (int k = 0; k < 16; k++) begin
            raw[3] = (k < 3) || (k >= 5 && k < 8);
            @(negedge clk);
        end
        end_mon();

        // A pulse of exactly N cycles does pass, and falls back after the same delay
        @(negedge clk);
        q.push_back(mk(201, 5'b00000, 6'd22, S_LAT, 0, 2));
        start_mon();
        for (int k = 0; k < 14; k++) begin
            raw[3] = (k < 4);
            @(negedge clk);
        end
        end_mon();

        // Temperature toggling 23/22 every 2 cycles
        @(negedge clk);
        q.push_back(mk(202, 5'b00000, 6'd22, 0, TOGGLE_TEDGE, TOGGLE_EV));
        start_mon();
        for (int k = 0; k < 20; k++) begin
            rtemp = (k < 16 && ((k / 2) % 2 == 0)) ? 6'd23 : 6'd22;
            @(negedge clk);
        end
        end_mon();

        // Reset asserted while SFA is mid-count
        @(negedge clk);
        raw   = 5'b00100;
        rtemp = 6'd20;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midreset_sfa",   300, int'(SFA),          0);
        check("midreset_temp",  300, int'(temperature),  20);
        check("midreset_event", 300, int'(sensor_event), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        q.push_back(mk(300, 5'b00100, 6'd20, S_LAT, 0, 1));
        start_mon();
        repeat (10) @(negedge clk);
        end_mon();

        check("queue_drained", 999, q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sensor_conditioner.md
# sensor_conditioner

Input-conditioning stage that sits directly upstream of `home_automation_system`. It synchronizes and debounces the five raw door/alarm/window/temperature sensor lines and the 6-bit temperature bus before they reach the priority encoder and counter enable. It also emits a one-cycle event pulse whenever any conditioned value changes. The conditioned outputs drive `SFD`, `SRD`, `SFA`, `SW`, `ST` and `temperature` of `home_automation_system` one-for-one.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before an output updates; legal range 1..255.
- `TEMP_W`, default 6: temperature bus width.
- `TEMP_RESET`, default 20: temperature output reset value. It is neutral: no heater (≤8) and no cooler (≥30).

Ports:
- `clk` input 1: single system clock; all flops on rising edge.
- `reset` input 1: asynchronous, active-low reset (asserted at 0); deassertion is synchronous to `clk` externally.
- `raw_SFD`, `raw_SRD`, `raw_SFA`, `raw_SW`, `raw_ST` input 1 each: asynchronous raw sensor lines.
- `raw_temperature` input TEMP_W: asynchronous raw temperature bus (unsigned °C); bits may be skewed.
- `SFD`, `SRD`, `SFA`, `SW`, `ST` output 1 each: debounced sensor values.
- `temperature` output TEMP_W: debounced temperature.
- `sensor_event` output 1: one-cycle pulse when any conditioned output changed.

## Operation
**Synchronizer**
- Every raw bit passes through a 2-flop synchronizer (s1→s2).
- Synchronizer flops reset to 0, except the temperature synchronizer, which resets to TEMP_RESET.

**Per-bit debounce (five sensors)**
- Each sensor has an independent counter `cnt`, width ceil(log2(DEBOUNCE_CYCLES+1)).
- If s2 == output: `cnt` ← 0.
- If s2 != output and `cnt` == DEBOUNCE_CYCLES−1: output ← s2, `cnt` ← 0.
- Otherwise: `cnt` ← `cnt`+1.
- A glitch shorter than DEBOUNCE_CYCLES cycles at s2 never reaches the output; the count restarts from 0 on any return to the output value.

**Temperature debounce (whole word)**
- Holds a previous-sample register `t_prev` (= s2 delayed one cycle) and one counter `tcnt`.
- If s2 != `t_prev` or s2 == `temperature`: `tcnt` ← 0.
- Else if `tcnt` == DEBOUNCE_CYCLES−1: `temperature` ← s2, `tcnt` ← 0.
- Otherwise: `tcnt` ← `tcnt`+1.
- The word updates atomically; intermediate skewed codes are never output.

**Event pulse**
- `sensor_event` is a registered pulse.
- It is high for exactly the cycle following any edge on which one or more of the six outputs changed value.
- Simultaneous changes on multiple outputs produce one pulse.
- Changes on back-to-back edges keep it high on consecutive cycles.

**Reset**
- Values while `reset`=0:
  - `SFD`/`SRD`/`SFA`/`SW`/`ST` = 0
  - `temperature` = TEMP_RESET
  - `sensor_event` = 0
  - all counters = 0
  - `t_prev` = TEMP_RESET
- Reset asserted mid-count discards the count immediately.

## Timing
- Sensor latency: raw change stable before edge 1 → s2 valid after edge 2 → output updates on edge 2+DEBOUNCE_CYCLES (edge 6 at default). `sensor_event` is high during the cycle after that edge.
- Temperature latency: the stable word reaches s2 on edge 2 and matches `t_prev` from edge 3. The output updates on edge 2+DEBOUNCE_CYCLES+1 (edge 7 at default).
- DEBOUNCE_CYCLES=1: sensor update on edge 3, temperature update on edge 4.
- Counters never wrap: the maximum count is DEBOUNCE_CYCLES−1, after which the counter is cleared.
- No combinational path from any input to any output.

## Configuration
- `SENSOR_COND_TEMP_DEBOUNCE_EN` defined: temperature uses the word debounce above.
- Undefined: `temperature` = s2 of the synchronizer directly (latency 2 edges), and `t_prev`/`tcnt` are not built.
- Undefined: `sensor_event` still pulses on temperature changes, which can occur on any cycle s2 changes.
- The five single-bit sensors are always debounced.

## Test plan
- **Reset values:** hold `reset`=0 with all raws at 1 and `raw_temperature`=45 → outputs 0, `temperature`=20, `sensor_event`=0; release reset → `SFD` etc. reach 1 on edge 6.
- **Single-sensor debounce:** `raw_SFD` 0→1 held (default N=4) → `SFD`=1 on edge 6 after change; `sensor_event` high exactly one cycle; other outputs unchanged.
- **Glitch rejection:** `raw_SW` pulse 3 cycles high, then low for 2 cycles, then 3 cycles high → `SW` stays 0 and no `sensor_event`.
- **Temperature step:** `raw_temperature` 20→31 held → `temperature`=31 on edge 7 with one event pulse. A 22→23 toggle every 2 cycles never updates the output (with `SENSOR_COND_TEMP_DEBOUNCE_EN`).
- **Simultaneous change:** `raw_SRD` and `raw_ST` rise in the same cycle → both outputs update on the same edge; a single one-cycle `sensor_event`.
- **Reset mid-count:** `raw_SFA`=1 for 3 stable cycles, then `reset` pulsed low, then released with `raw_SFA`=1 → `SFA`=0 during reset, then 1 only after a full 2+4 edges from release.
